axi_slave_rd: RTL
=================

# axi_slave_rd

AXI read-channel slave that answers the read requests issued by `axi_master_rd`. It accepts one AR transaction at a time and looks up the beats in an internal word-addressed memory. It returns `ar_len+1` R beats with the correct `r_last` and `r_resp`, honouring `r_ready` backpressure. A backdoor write port preloads and modifies memory contents, so the block serves as the system read target and as the bench model behind `axi_master_rd`.

## Interface
- `ADDR_BITS`, 32, address width (from `define.sv`)
- `DATA_BITS`, 32, data width; power of 2, minimum 8
- `LEN_BITS`, 8, burst-length field width
- `SIZE_BITS`, 3, burst-size field width
- `MEM_DEPTH`, 256, memory depth in `DATA_BITS` words

Ports:
- `aclk`  in  1  clock. One clock; reset is synchronous and active-high.
- `areset`  in  1  synchronous, active-high reset
- `ar_addr`  in  ADDR_BITS  burst start byte address
- `ar_len`  in  LEN_BITS  beats minus 1
- `ar_size`  in  SIZE_BITS  log2 of bytes per beat
- `ar_burst`  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- `ar_cache`  in  4  ignored
- `ar_valid`  in  1  AR request valid
- `ar_ready`  out  1  AR accept
- `r_data`  out  DATA_BITS  read data
- `r_valid`  out  1  R beat valid
- `r_last`  out  1  final beat of the burst
- `r_resp`  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
- `r_ready`  in  1  master accepts the beat
- `mem_we`  in  1  backdoor write enable
- `mem_waddr`  in  $clog2(MEM_DEPTH)  backdoor word index
- `mem_wdata`  in  DATA_BITS  backdoor write data

## Operation
- Two-state FSM:
  - IDLE: `ar_ready`=1. When `ar_valid`&`ar_ready`, the block latches addr/len/size/burst, clears the beat counter, loads beat 0 into the R registers, and moves to DATA.
  - DATA: `ar_ready`=0 and `r_valid`=1. On `r_valid`&`r_ready`:
    - not last: advance the address and load the next beat.
    - last: clear `r_valid`/`r_last` and return to IDLE.
- Word index is `addr >> log2(DATA_BITS/8)`.
- Beat data:
  - in-range address: `mem[index]`.
  - index ≥ MEM_DEPTH: data 0, resp DECERR (evaluated per beat).
- Burst-level SLVERR (every beat is data 0, resp SLVERR, and still `ar_len+1` beats with a correct `r_last`):
  - `ar_size` > log2(DATA_BITS/8)
  - `ar_burst`=11
  - WRAP with `ar_len` ∉ {1,3,7,15}
- Address progression, with B=1<<size:
  - FIXED: address constant.
  - INCR: next = (addr & ~(B-1)) + B, modulo 2^ADDR_BITS.
  - WRAP: T=B*(len+1) and base = addr & ~(T-1); next = addr+B, but if next = base+T then next = base.
- `r_last` = (beat_cnt == len_latched). The beat counter is LEN_BITS wide, so len=255 gives 256 beats.
- Backdoor write: `mem[mem_waddr] <= mem_wdata` on any cycle.
  - A beat load in the same cycle as a write to the same word sees the old data.
  - A beat already presented is never altered.

## Timing
- Reset values while `areset` is held: `ar_ready` 0, `r_valid` 0, `r_last` 0, `r_data` 0, `r_resp` 00, FSM in IDLE. Memory contents are not reset.
- `ar_ready` rises in the first cycle after `areset` deasserts.
- Latency:
  - AR handshake in cycle T puts beat 0 on R in T+1.
  - Each R handshake in cycle T presents the next beat in T+1, so throughput is 1 beat/cycle with `r_ready` held high.
  - The last R handshake in cycle T gives `r_valid`=0 and `ar_ready`=1 in T+1. This is one bubble; a new AR handshake can happen in T+1.
- Stall: while `r_valid`&!`r_ready`, `r_data`, `r_resp` and `r_last` hold stable.
- `ar_valid` is not sampled in DATA.
- Reset mid-burst: the burst is abandoned and all outputs take their reset values at the next edge.

## Structure
- Package `axi_pkg`:
  - burst encodings (FIXED/INCR/WRAP)
  - response encodings (OKAY/SLVERR/DECERR)
  - `rd_slv_state_t` enum {IDLE, DATA}
- Width macros stay in `define.sv`.
- Sub-module `axi_burst_addr`: combinational next-address and burst-legality calculator (addr, size, len, burst → next_addr, illegal). It is shared later with the write slave.

## Test plan
Memory is preloaded with `mem[i]=0x1000+i`. Defaults: DATA_BITS=32, size=2.

- INCR, addr 0x10, len 3, `r_ready`=1 → data 0x1004, 0x1005, 0x1006, 0x1007; `r_last` only on the 4th beat; resp 00; first `r_valid` one cycle after the AR handshake; `ar_ready`=1 the cycle after the last beat.
- WRAP, addr 0x18, len 3 → data 0x1006, 0x1007, 0x1004, 0x1005.
- FIXED, addr 0x20, len 2 → data 0x1008 three times, `r_last` on the 3rd beat.
- INCR len 3 with `r_ready` pattern 1,0,1,0,… → 4 beats in 8 cycles; outputs stable on each 0 cycle; no beat lost or duplicated.
- Error cases, each returning `len+1` beats with data 0:
  - addr 0x400, len 0 → DECERR.
  - size 3 → SLVERR on every beat.
  - WRAP with len 2 → SLVERR on every beat.
- `areset` asserted after beat 1 of a len 7 burst → next cycle `r_valid`=0 and `ar_ready`=0; `ar_ready`=1 in the first cycle after release. A following INCR addr 0x0 len 0 returns 0x1000.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-slave FSM state type.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } rd_slv_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address and burst-legality calculator,
// shared between the read and write slaves.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3
) (
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [SIZE_BITS-1:0] size_i,
  input  logic [LEN_BITS-1:0]  len_i,
  input  logic [1:0]           burst_i,
  output logic [ADDR_BITS-1:0] next_addr_o,
  output logic                 illegal_o
);

  localparam logic [SIZE_BITS-1:0] MAX_SIZE = SIZE_BITS'($clog2(DATA_BITS / 8));

  logic [ADDR_BITS-1:0] bytes;
  logic [ADDR_BITS-1:0] total;
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] incr_sum;
  logic [2:0]           wrap_shift;
  logic                 wrap_len_ok;

  // Legal wrap lengths are powers of two, so the wrap span is a shift, not a multiply.
  always_comb begin
    wrap_len_ok = 1'b1;
    wrap_shift  = 3'd1;
    case (len_i)
      LEN_BITS'(1):  wrap_shift = 3'd1;
      LEN_BITS'(3):  wrap_shift = 3'd2;
      LEN_BITS'(7):  wrap_shift = 3'd3;
      LEN_BITS'(15): wrap_shift = 3'd4;
      default:       wrap_len_ok = 1'b0;
    endcase
  end

  always_comb begin
    bytes    = ADDR_BITS'(1) << size_i;
    total    = bytes << wrap_shift;
    base     = addr_i & ~(total - ADDR_BITS'(1));
    incr_sum = addr_i + bytes;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = (addr_i & ~(bytes - ADDR_BITS'(1))) + bytes;
      BURST_WRAP:  next_addr_o = (incr_sum == base + total) ? base : incr_sum;
      default:     next_addr_o = addr_i;
    endcase
    illegal_o = (size_i > MAX_SIZE) || (burst_i == BURST_RSVD) ||
                ((burst_i == BURST_WRAP) && !wrap_len_ok);
  end

endmodule

// File: rtl/axi_slave_rd.sv
// AXI read-channel slave: one AR at a time, beats served from an internal
// word-addressed memory with a backdoor write port.
module axi_slave_rd
  import axi_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_BITS-1:0]         ar_addr,
  input  logic [LEN_BITS-1:0]          ar_len,
  input  logic [SIZE_BITS-1:0]         ar_size,
  input  logic [1:0]                   ar_burst,
  input  logic [3:0]                   ar_cache,
  input  logic                         ar_valid,
  output logic                         ar_ready,
  output logic [DATA_BITS-1:0]         r_data,
  output logic                         r_valid,
  output logic                         r_last,
  output logic [1:0]                   r_resp,
  input  logic                         r_ready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_BITS-1:0]         mem_wdata
);

  localparam int OFF = $clog2(DATA_BITS / 8);
  localparam int AW  = $clog2(MEM_DEPTH);

  logic [DATA_BITS-1:0] mem [MEM_DEPTH];

  rd_slv_state_t        state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [SIZE_BITS-1:0] size_q;
  logic [1:0]           burst_q;
  logic                 err_q;
  logic [LEN_BITS-1:0]  cnt_q;
  logic [DATA_BITS-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  logic                 r_last_q;

  logic                 ar_hs, r_hs, load;
  logic [ADDR_BITS-1:0] calc_addr, calc_next;
  logic [LEN_BITS-1:0]  calc_len;
  logic [SIZE_BITS-1:0] calc_size;
  logic [1:0]           calc_burst;
  logic                 calc_illegal;
  logic [ADDR_BITS-1:0] load_addr, load_idx_full;
  logic                 load_err, load_in_range;
  logic                 unused_bits;

  // In IDLE the calculator checks the incoming request; in DATA it steps the latched burst.
  always_comb begin
    calc_addr     = (state_q == IDLE) ? ar_addr  : addr_q;
    calc_len      = (state_q == IDLE) ? ar_len   : len_q;
    calc_size     = (state_q == IDLE) ? ar_size  : size_q;
    calc_burst    = (state_q == IDLE) ? ar_burst : burst_q;
    load_addr     = (state_q == IDLE) ? ar_addr  : calc_next;
    load_err      = (state_q == IDLE) ? calc_illegal : err_q;
    load_idx_full = load_addr >> OFF;
    load_in_range = load_idx_full < ADDR_BITS'(MEM_DEPTH);
  end

  axi_burst_addr #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS),
    .LEN_BITS (LEN_BITS),
    .SIZE_BITS(SIZE_BITS)
  ) u_burst_addr (
    .addr_i     (calc_addr),
    .size_i     (calc_size),
    .len_i      (calc_len),
    .burst_i    (calc_burst),
    .next_addr_o(calc_next),
    .illegal_o  (calc_illegal)
  );

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_valid) state_d = DATA;
      DATA:    if (r_ready && r_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (state_q == IDLE) && !areset;
    r_valid  = (state_q == DATA);
    ar_hs    = ar_valid && ar_ready;
    r_hs     = r_valid && r_ready;
    load     = ar_hs || (r_hs && !r_last_q);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      r_last_q <= 1'b0;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        addr_q   <= ar_addr;
        len_q    <= ar_len;
        size_q   <= ar_size;
        burst_q  <= ar_burst;
        err_q    <= calc_illegal;
        cnt_q    <= '0;
        r_last_q <= (ar_len == '0);
      end else if (r_hs) begin
        if (r_last_q) begin
          r_last_q <= 1'b0;
        end else begin
          addr_q   <= calc_next;
          cnt_q    <= cnt_q + LEN_BITS'(1);
          r_last_q <= ((cnt_q + LEN_BITS'(1)) == len_q);
        end
      end
      // Registered memory read; a same-cycle backdoor write is not visible here.
      if (load) begin
        if (load_err) begin
          r_data_q <= '0;
          r_resp_q <= RESP_SLVERR;
        end else if (!load_in_range) begin
          r_data_q <= '0;
          r_resp_q <= RESP_DECERR;
        end else begin
          r_data_q <= mem[load_idx_full[AW-1:0]];
          r_resp_q <= RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign r_data      = r_data_q;
  assign r_resp      = r_resp_q;
  assign r_last      = r_last_q;
  assign unused_bits = ^{ar_cache, load_idx_full[ADDR_BITS-1:AW]};

endmodule
